fir_response_analyzer: RTL and testbench
========================================

// Module: fir_response_analyzer
// PURPOSE
//   Receive-side companion to the FIR filter: consumes the filter's 24-bit signed output stream.
//   Skips a settling transient, then measures one window of samples: max, min, peak-to-peak and
//   positive-going zero crossings. Results leave on a valid/ready handshake for the host/bench.
//   Sits directly after FIRFilterS25 in the datapath, in the same clk domain.
// PARAMETERS
//   DATA_W  24    sample width, two's complement
//   WINDOW  1024  valid samples measured per run (>=1)
//   SETTLE  64    valid samples discarded after start (0 = none)
//   CNT_W   16    width of zero-crossing and settle/window counters; saturating
// PORTS
//   clk        in   1         rising-edge clock
//   reset      in   1         synchronous, active-high
//   start      in   1         begin a measurement run (honoured in IDLE, or on the REPORT handshake cycle)
//   in_valid   in   1         in_data qualifier
//   in_data    in   DATA_W    signed filter output sample
//   res_valid  out  1         result available
//   res_ready  in   1         consumer accepts result
//   res_max    out  DATA_W    signed window maximum
//   res_min    out  DATA_W    signed window minimum
//   res_p2p    out  DATA_W+1  res_max - res_min, unsigned, never wraps
//   res_zc     out  CNT_W     count of positive-going zero crossings
//   busy       out  1         high in SETTLE or ACQUIRE
//   overrun    out  1         sticky: in_valid seen while in REPORT; cleared by an accepted start
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; internal counters, trackers and prev_neg cleared.
//   FSM IDLE -> SETTLE -> ACQUIRE -> REPORT -> IDLE.
//   IDLE: start=1 -> SETTLE (-> ACQUIRE directly if SETTLE==0); counters cleared; overrun cleared.
//     in_valid ignored.
//   SETTLE: count in_valid cycles; the SETTLE-th valid sample is discarded and moves to ACQUIRE.
//   ACQUIRE: the first valid sample loads max=min=sample and prev_neg=sample[MSB]; no crossing
//     is counted on it. Each later valid sample: max/min update by signed compare.
//     Zero crossing iff prev_neg && !sample[MSB] (a sample of 0 counts as non-negative); res_zc
//     saturates at all-ones. prev_neg is then updated.
//     The WINDOW-th valid sample enters REPORT.
//   REPORT: res_valid=1 at the edge after the WINDOW-th sample's edge (latency 1 clk).
//     res_* are registered and stable until the handshake. p2p is computed at DATA_W+1 bits by
//     sign-extending both operands.
//     res_valid && res_ready -> IDLE, or -> SETTLE if start=1 in the same cycle (back-to-back run).
//     res_* hold their last values in IDLE until the next REPORT.
//   start is ignored while busy. in_valid while in REPORT is dropped and sets overrun.
//   reset mid-run: the run is abandoned immediately and no result is emitted.
//   in_valid gaps are allowed in any state; only valid cycles advance the counters.
// STRUCTURE
//   Shared package: DATA_W default, state encoding (IDLE/SETTLE/ACQUIRE/REPORT localparams),
//     counter width.
//   One sub-module: fir_peak_zc_tracker. Inputs: clear, load_first, update, sample.
//     Outputs: max, min, zc.
//   Top level holds the FSM, the counters, the result registers and the handshake.
// TESTING (WINDOW=8, SETTLE=2 unless noted)
//   1 Reset, then idle 5 clk -> res_valid=0, busy=0, overrun=0, every res_* = 0.
//   2 start; 10 valid samples of 100 -> res_max=100, res_min=100, res_p2p=0, res_zc=0.
//     res_valid rises 1 clk after the 10th sample.
//   3 start; settle 0,0, then -1000,-1000,1000,1000,-1000,-1000,1000,1000
//     -> max=1000, min=-1000, p2p=2000, zc=2.
//   4 Window containing 24'h7FFFFF and 24'h800000 -> res_p2p=25'd16777215 (no wrap).
//   5 res_ready=0 for 10 clk with in_valid pulses in REPORT -> res_* stable, overrun=1.
//     Then res_ready=1 with start=1 -> state SETTLE, overrun=0.
//   6 reset asserted mid-ACQUIRE (5th sample) -> all outputs 0. A new start gives a correct
//     result with no carry-over of the old min/max/zc.

Source files
------------

// File: rtl/fir_response_analyzer_pkg.sv
// Shared definitions for the FIR response analyzer: default widths and FSM state encoding.
package fir_response_analyzer_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int CNT_W_DEF  = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_SETTLE  = 2'd1;
    localparam state_t ST_ACQUIRE = 2'd2;
    localparam state_t ST_REPORT  = 2'd3;

endpackage

// File: rtl/fir_response_analyzer_tracker.sv
// Running max/min and positive-going zero-crossing tracker. Outputs already include the
// current cycle's sample, so the parent can capture a final result on the last sample's edge.
module fir_peak_zc_tracker
    import fir_response_analyzer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load_first,
    input  logic              update,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] max,
    output logic [DATA_W-1:0] min,
    output logic [CNT_W-1:0]  zc
);

    logic [DATA_W-1:0] max_q;
    logic [DATA_W-1:0] min_q;
    logic [CNT_W-1:0]  zc_q;
    logic              prev_neg_q;
    logic              prev_neg_d;

    always_comb begin
        max        = max_q;
        min        = min_q;
        zc         = zc_q;
        prev_neg_d = prev_neg_q;
        if (clear) begin
            max        = '0;
            min        = '0;
            zc         = '0;
            prev_neg_d = 1'b0;
        end else if (load_first) begin
            max        = sample;
            min        = sample;
            zc         = '0;
            prev_neg_d = sample[DATA_W-1];
        end else if (update) begin
            if ($signed(sample) > $signed(max_q)) max = sample;
            if ($signed(sample) < $signed(min_q)) min = sample;
            // A zero sample counts as non-negative; the count saturates at all-ones.
            if (prev_neg_q && !sample[DATA_W-1] && (zc_q != '1)) zc = zc_q + CNT_W'(1);
            prev_neg_d = sample[DATA_W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            max_q      <= '0;
            min_q      <= '0;
            zc_q       <= '0;
            prev_neg_q <= 1'b0;
        end else begin
            max_q      <= max;
            min_q      <= min;
            zc_q       <= zc;
            prev_neg_q <= prev_neg_d;
        end
    end

endmodule

// File: rtl/fir_response_analyzer.sv
// Measures one window of FIR output samples after a settling transient and reports
// max/min/peak-to-peak/zero-crossings over a valid/ready result handshake.
module fir_response_analyzer
    import fir_response_analyzer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int WINDOW = 1024,
    parameter int SETTLE = 64,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_max,
    output logic [DATA_W-1:0] res_min,
    output logic [DATA_W:0]   res_p2p,
    output logic [CNT_W-1:0]  res_zc,
    output logic              busy,
    output logic              overrun,
    output logic [1:0]        state
);

    // Handshake: a result transfers on any cycle where res_valid && res_ready are both high;
    // res_valid stays high and res_* stay constant until that cycle.

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW - 1);
    localparam state_t           RUN_ENTRY   = (SETTLE == 0) ? ST_ACQUIRE : ST_SETTLE;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  settle_cnt;
    logic [CNT_W-1:0]  win_cnt;
    logic              accept;
    logic              go;
    logic              settle_hit;
    logic              acq_sample;
    logic              window_hit;
    logic [DATA_W-1:0] trk_max;
    logic [DATA_W-1:0] trk_min;
    logic [CNT_W-1:0]  trk_zc;

    assign accept     = (state_q == ST_REPORT) && res_ready;
    assign go         = ((state_q == ST_IDLE) || accept) && start;
    assign settle_hit = (state_q == ST_SETTLE) && in_valid && (settle_cnt == SETTLE_LAST);
    assign acq_sample = (state_q == ST_ACQUIRE) && in_valid;
    assign window_hit = acq_sample && (win_cnt == WINDOW_LAST);

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = RUN_ENTRY;
            ST_SETTLE:  if (settle_hit) state_d = ST_ACQUIRE;
            ST_ACQUIRE: if (window_hit) state_d = ST_REPORT;
            ST_REPORT:  if (accept) state_d = start ? RUN_ENTRY : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_SETTLE) || (state_q == ST_ACQUIRE);
        res_valid = (state_q == ST_REPORT);
        state     = state_q;
    end

    always_ff @(posedge clk) begin
        if (reset || go) begin
            settle_cnt <= '0;
            win_cnt    <= '0;
        end else begin
            if ((state_q == ST_SETTLE) && in_valid && (settle_cnt != '1))
                settle_cnt <= settle_cnt + CNT_W'(1);
            if (acq_sample && (win_cnt != '1))
                win_cnt <= win_cnt + CNT_W'(1);
        end
    end

    fir_peak_zc_tracker #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_tracker (
        .clk        (clk),
        .reset      (reset),
        .clear      (go),
        .load_first (acq_sample && (win_cnt == '0)),
        .update     (acq_sample && (win_cnt != '0)),
        .sample     (in_data),
        .max        (trk_max),
        .min        (trk_min),
        .zc         (trk_zc)
    );

    // p2p is taken at DATA_W+1 bits from sign-extended operands, so it can never wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_max <= '0;
            res_min <= '0;
            res_p2p <= '0;
            res_zc  <= '0;
        end else if (window_hit) begin
            res_max <= trk_max;
            res_min <= trk_min;
            res_p2p <= {trk_max[DATA_W-1], trk_max} - {trk_min[DATA_W-1], trk_min};
            res_zc  <= trk_zc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || go)                           overrun <= 1'b0;
        else if ((state_q == ST_REPORT) && in_valid) overrun <= 1'b1;
    end

endmodule

// File: tb/tb_fir_response_analyzer.sv
// Self-checking bench for fir_response_analyzer with WINDOW=8, SETTLE=2.
module tb_fir_response_analyzer;
    import fir_response_analyzer_pkg::*;

    localparam int DW  = 24;
    localparam int CW  = 16;
    localparam int EW  = DW + DW + (DW + 1) + CW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [DW-1:0] res_max;
    logic [DW-1:0] res_min;
    logic [DW:0]   res_p2p;
    logic [CW-1:0] res_zc;
    logic          busy;
    logic          overrun;
    logic [1:0]    state;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] last_exp;
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    fir_response_analyzer #(
        .DATA_W (DW),
        .WINDOW (8),
        .SETTLE (2),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_max   (res_max),
        .res_min   (res_min),
        .res_p2p   (res_p2p),
        .res_zc    (res_zc),
        .busy      (busy),
        .overrun   (overrun),
        .state     (state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: samples 2..9 form the window; packed as {max, min, p2p, zc}.
    function automatic logic [EW-1:0] model(input logic signed [DW-1:0] s[10]);
        int mx, mn, zc, v;
        bit pn;
        logic [DW-1:0] omx, omn;
        logic [DW:0]   op2p;
        logic [CW-1:0] ozc;
        mx = int'(s[2]);
        mn = mx;
        zc = 0;
        pn = (mx < 0);
        for (int i = 3; i < 10; i++) begin
            v = int'(s[i]);
            if (v > mx) mx = v;
            if (v < mn) mn = v;
            if (pn && v >= 0) zc++;
            pn = (v < 0);
        end
        omx  = DW'(mx);
        omn  = DW'(mn);
        op2p = (DW + 1)'(mx - mn);
        ozc  = CW'(zc);
        return {omx, omn, op2p, ozc};
    endfunction

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input logic signed [DW-1:0] s[10], input int lo, input int hi,
                        input bit gaps);
        for (int i = lo; i <= hi; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                step();
            end
            in_valid = 1'b1;
            in_data  = s[i];
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string name);
        int waited;
        logic [EW-1:0] e;
        waited = 0;
        while (res_valid !== 1'b1 && waited < 40) begin
            step();
            waited++;
        end
        n_cmp++;
        if (res_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s timeout: res_valid=%b required 1", name, res_valid);
            return;
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s queue: result seen with %0d expected entries", name, exp_q.size());
            return;
        end
        e = exp_q.pop_front();
        last_exp = e;
        n_cmp++;
        if (res_max !== e[EW-1 -: DW]) begin
            n_bad++;
            $display("FAIL %s max: got %h required %h", name, res_max, e[EW-1 -: DW]);
        end
        n_cmp++;
        if (res_min !== e[EW-DW-1 -: DW]) begin
            n_bad++;
            $display("FAIL %s min: got %h required %h", name, res_min, e[EW-DW-1 -: DW]);
        end
        n_cmp++;
        if (res_p2p !== e[CW +: DW + 1]) begin
            n_bad++;
            $display("FAIL %s p2p: got %0d required %0d", name, res_p2p, e[CW +: DW + 1]);
        end
        n_cmp++;
        if (res_zc !== e[CW-1:0]) begin
            n_bad++;
            $display("FAIL %s zc: got %0d required %0d", name, res_zc, e[CW-1:0]);
        end
    endtask

    task automatic accept(input bit with_start);
        res_ready = 1'b1;
        start     = with_start;
        step();
        res_ready = 1'b0;
        start     = 1'b0;
    endtask

    task automatic check_outputs_zero(input string name);
        n_cmp++;
        if ({res_valid, busy, overrun, res_max, res_min, res_p2p, res_zc} !== '0) begin
            n_bad++;
            $display("FAIL %s outputs: got v=%b b=%b o=%b max=%h min=%h p2p=%h zc=%h required all 0",
                     name, res_valid, busy, overrun, res_max, res_min, res_p2p, res_zc);
        end
        n_cmp++;
        if (state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL %s state: got %0d required %0d", name, state, ST_IDLE);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_outputs_zero("reset");
    endtask

    task automatic test_constant();
        logic signed [DW-1:0] s[10];
        for (int i = 0; i < 10; i++) s[i] = 24'sd100;
        exp_q.push_back(model(s));
        start_run();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL constant busy: got %b required 1", busy);
        end
        feed(s, 0, 8, 1'b0);
        n_cmp++;
        if (res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL constant early_valid: got %b required 0", res_valid);
        end
        feed(s, 9, 9, 1'b0);
        n_cmp++;
        if (res_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL constant latency: res_valid=%b required 1 one clk after 10th sample", res_valid);
        end
        expect_result("constant");
        accept(1'b0);
        n_cmp++;
        if (res_valid !== 1'b0 || state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL constant release: valid=%b state=%0d required 0/%0d", res_valid, state, ST_IDLE);
        end
    endtask

    task automatic test_crossings();
        logic signed [DW-1:0] s[10];
        s = '{24'sd0, 24'sd0, -24'sd1000, -24'sd1000, 24'sd1000, 24'sd1000,
              -24'sd1000, -24'sd1000, 24'sd1000, 24'sd1000};
        exp_q.push_back(model(s));
        start_run();
        feed(s, 0, 9, 1'b1);
        expect_result("crossings");
        n_cmp++;
        if (res_zc !== 16'd2 || res_p2p !== 25'd2000) begin
            n_bad++;
            $display("FAIL crossings fixed: zc=%0d p2p=%0d required 2/2000", res_zc, res_p2p);
        end
        accept(1'b0);
    endtask

    task automatic test_extremes();
        logic signed [DW-1:0] s[10];
        s = '{24'sd5, 24'sd5, 24'sh7FFFFF, 24'sh800000, 24'sd0, 24'sd1,
              -24'sd1, 24'sd5, -24'sd5, 24'sh7FFFFF};
        exp_q.push_back(model(s));
        start_run();
        feed(s, 0, 9, 1'b0);
        expect_result("extremes");
        n_cmp++;
        if (res_p2p !== 25'd16777215) begin
            n_bad++;
            $display("FAIL extremes p2p_nowrap: got %0d required 16777215", res_p2p);
        end
        accept(1'b0);
    endtask

    task automatic test_overrun();
        logic signed [DW-1:0] s[10];
        for (int i = 0; i < 10; i++) s[i] = 24'(-500 + 100 * i);
        exp_q.push_back(model(s));
        start_run();
        feed(s, 0, 9, 1'b0);
        expect_result("overrun_run");
        for (int c = 0; c < 10; c++) begin
            in_valid = (c % 2 == 0);
            in_data  = 24'($urandom);
            step();
            n_cmp++;
            if (res_valid !== 1'b1 || {res_max, res_min, res_p2p, res_zc} !== last_exp) begin
                n_bad++;
                $display("FAIL overrun stable: cycle %0d valid=%b got %h required %h",
                         c, res_valid, {res_max, res_min, res_p2p, res_zc}, last_exp);
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun set: got %b required 1", overrun);
        end
        for (int i = 0; i < 10; i++) s[i] = 24'(i * 7 - 30);
        exp_q.push_back(model(s));
        accept(1'b1);
        n_cmp++;
        if (state !== ST_SETTLE || overrun !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun restart: state=%0d overrun=%b busy=%b required %0d/0/1",
                     state, overrun, busy, ST_SETTLE);
        end
        feed(s, 0, 9, 1'b1);
        expect_result("overrun_next");
        accept(1'b0);
    endtask

    task automatic test_reset_mid();
        logic signed [DW-1:0] s[10];
        s = '{24'sd1, 24'sd1, 24'sd50000, -24'sd50000, 24'sd40000, -24'sd3, 24'sd9,
              24'sd2, 24'sd2, 24'sd2};
        start_run();
        feed(s, 0, 5, 1'b0);
        in_valid = 1'b1;
        in_data  = s[6];
        reset    = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        check_outputs_zero("reset_mid");
        s = '{24'sd0, 24'sd0, 24'sd10, 24'sd12, 24'sd11, 24'sd15,
              24'sd13, 24'sd20, 24'sd14, 24'sd16};
        exp_q.push_back(model(s));
        start_run();
        feed(s, 0, 9, 1'b1);
        expect_result("after_reset");
        accept(1'b0);
    endtask

    task automatic test_back_to_back();
        logic signed [DW-1:0] s[10];
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++)
                s[i] = 24'($urandom_range(0, 4000)) - 24'sd2000;
            exp_q.push_back(model(s));
            if (r == 0) start_run();
            feed(s, 0, 9, 1'b1);
            expect_result("back_to_back");
            accept(r < 2);
            n_cmp++;
            if (busy !== (r < 2)) begin
                n_bad++;
                $display("FAIL back_to_back busy: run %0d got %b required %b", r, busy, r < 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_crossings();
        test_extremes();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: got %0d pending results required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
